// File: rtl/clk_div_mon.sv
// Divided-clock monitor: measures period and high time of i_sig in i_clk cycles and
// republishes stable measurements through a value/toggle handshake.
module clk_div_mon #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_N    = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_tog,
  output logic             o_stable,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [3:0]       StableN = 4'(STABLE_N);

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StLost} state_e;

  logic sig_sync;
  logic sig_dly_q;
  logic rise;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign sig_sync = i_sig;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    // Shift toward the MSB; the cast drops the oldest stage.
    always_comb begin
      sync_d = SYNC_STAGES'({sync_q, i_sig});
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign sig_sync = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sig_dly_q <= 1'b0;
    end else begin
      sig_dly_q <= sig_sync;
    end
  end

  assign rise = sig_sync & ~sig_dly_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] prev_per_q, prev_per_d;
  logic [CNT_W-1:0] prev_high_q, prev_high_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             tog_q, tog_d;
  logic             stable_q, stable_d;
  logic             timeout_q, timeout_d;
  logic             pend_q, pend_d;

  logic       meas_same;
  logic       meas_differs;
  logic [3:0] match_nxt;

  // match_q == 0 means there is no previous measurement to compare against.
  assign meas_same    = (match_q != 4'd0) && (cnt_q == prev_per_q) && (hcnt_q == prev_high_q);
  assign meas_differs = (cnt_q != per_q) || (hcnt_q != high_q);
  assign match_nxt    = meas_same ? ((match_q < StableN) ? match_q + 4'd1 : match_q) : 4'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    prev_per_d  = prev_per_q;
    prev_high_d = prev_high_q;
    match_d     = match_q;
    per_d       = per_q;
    high_d      = high_q;
    tog_d       = tog_q;
    stable_d    = stable_q;
    timeout_d   = timeout_q;
    pend_d      = 1'b0;

    // Data registered last cycle; announce it now so it is settled before the toggle.
    if (pend_q) begin
      tog_d    = ~tog_q;
      stable_d = 1'b1;
    end

    if (!i_en) begin
      state_d     = StIdle;
      cnt_d       = '0;
      hcnt_d      = '0;
      prev_per_d  = '0;
      prev_high_d = '0;
      match_d     = 4'd0;
      tog_d       = tog_q;
      stable_d    = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
        end

        StArm: begin
          if (rise) begin
            state_d = StMeas;
            cnt_d   = CntOne;
            hcnt_d  = CntOne;
          end else if (cnt_q == CntMax) begin
            state_d   = StLost;
            timeout_d = 1'b1;
            stable_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end

        StMeas: begin
          if (rise) begin
            cnt_d       = CntOne;
            hcnt_d      = CntOne;
            prev_per_d  = cnt_q;
            prev_high_d = hcnt_q;
            match_d     = match_nxt;
            if (stable_q && meas_differs) begin
              stable_d = 1'b0;
            end
            if ((match_nxt == StableN) && (!stable_q || meas_differs)) begin
              per_d  = cnt_q;
              high_d = hcnt_q;
              pend_d = 1'b1;
            end
          end else if (cnt_q == CntMax) begin
            state_d   = StLost;
            timeout_d = 1'b1;
            stable_d  = 1'b0;
          end else begin
            // hcnt never exceeds cnt, so it cannot wrap before cnt saturates.
            cnt_d = cnt_q + CntOne;
            if (sig_sync) begin
              hcnt_d = hcnt_q + CntOne;
            end
          end
        end

        StLost: begin
          stable_d = 1'b0;
          if (rise) begin
            state_d   = StMeas;
            timeout_d = 1'b0;
            match_d   = 4'd0;
            cnt_d     = CntOne;
            hcnt_d    = CntOne;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      prev_per_q  <= '0;
      prev_high_q <= '0;
      match_q     <= 4'd0;
      per_q       <= '0;
      high_q      <= '0;
      tog_q       <= 1'b0;
      stable_q    <= 1'b0;
      timeout_q   <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      prev_per_q  <= prev_per_d;
      prev_high_q <= prev_high_d;
      match_q     <= match_d;
      per_q       <= per_d;
      high_q      <= high_d;
      tog_q       <= tog_d;
      stable_q    <= stable_d;
      timeout_q   <= timeout_d;
      pend_q      <= pend_d;
    end
  end

  assign o_period  = per_q;
  assign o_high    = high_q;
  assign o_tog     = tog_q;
  assign o_stable  = stable_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_clk_div_mon.sv
// Bench for clk_div_mon: event-level reference model driven by the generated waveform,
// with expectations checked a fixed latency after every input rising edge.
module tb_clk_div_mon;

  localparam int CntW = 8;
  localparam int Sn   = 2;
  localparam int Lat  = 4;

  logic            clk;
  logic            rstn;
  logic            en;
  logic            sig;
  logic [CntW-1:0] per;
  logic [CntW-1:0] hi;
  logic            tog;
  logic            stb;
  logic            tmo;

  clk_div_mon #(
    .CNT_W      (CntW),
    .SYNC_STAGES(2),
    .STABLE_N   (Sn)
  ) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_en     (en),
    .i_sig    (sig),
    .o_period (per),
    .o_high   (hi),
    .o_tog    (tog),
    .o_stable (stb),
    .o_timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int per;
    int hi;
    int tog;
    int stb;
    int tmo;
  } exp_t;

  exp_t q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state, expressed in terms of observed edges.
  int m_armed, m_mcnt, m_pp, m_ph, m_per, m_hi, m_tog, m_stb, m_tmo;
  int last_rise, high_since, sig_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".period"},  32'(per), e.per);
    chk({tag, ".high"},    32'(hi),  e.hi);
    chk({tag, ".tog"},     32'(tog), e.tog);
    chk({tag, ".stable"},  32'(stb), e.stb);
    chk({tag, ".timeout"}, 32'(tmo), e.tmo);
  endtask

  task automatic model_reset();
    m_armed = 0; m_mcnt = 0; m_pp = 0; m_ph = 0;
    m_per = 0; m_hi = 0; m_tog = 0; m_stb = 0; m_tmo = 0;
    last_rise = cyc; high_since = 0;
  endtask

  task automatic model_disable();
    m_armed = 0; m_mcnt = 0; m_stb = 0; m_tmo = 0;
  endtask

  task automatic on_rise();
    int p;
    int h;
    int differs;
    int was_stable;
    exp_t e;
    p = cyc - last_rise;
    h = high_since;
    last_rise  = cyc;
    high_since = 0;
    if (m_armed == 0) begin
      // First edge after enable or loss of signal only restarts counting.
      m_armed = 1;
      m_tmo   = 0;
      m_mcnt  = 0;
    end else begin
      if (m_mcnt != 0 && p == m_pp && h == m_ph) begin
        if (m_mcnt < Sn) m_mcnt++;
      end else begin
        m_mcnt = 1;
      end
      m_pp = p;
      m_ph = h;
      was_stable = m_stb;
      differs = (p != m_per || h != m_hi) ? 1 : 0;
      if (was_stable == 1 && differs == 1) m_stb = 0;
      if (m_mcnt == Sn && (was_stable == 0 || differs == 1)) begin
        m_per = p;
        m_hi  = h;
        m_tog = 1 - m_tog;
        m_stb = 1;
      end
    end
    e = '{cyc + Lat, m_per, m_hi, m_tog, m_stb, m_tmo};
    q.push_back(e);
  endtask

  // One reference-clock cycle: settle due checks, then drive the next input level.
  task automatic tick(input logic v);
    exp_t e;
    @(negedge clk);
    cyc++;
    while (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk_all("edge", e);
    end
    sig = v;
    if (v && sig_prev == 0 && en) on_rise();
    if (v) high_since++;
    sig_prev = v ? 1 : 0;
  endtask

  task automatic run(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < h; i++) tick(1'b1);
      for (int i = 0; i < l; i++) tick(1'b0);
    end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  initial begin
    exp_t zero;
    int p;
    int h;
    int n;
    zero = '{0, 0, 0, 0, 0, 0};
    rstn = 1'b0;
    en   = 1'b0;
    sig  = 1'b0;
    sig_prev = 0;
    model_reset();

    repeat (3) @(negedge clk);
    chk_all("reset", zero);
    rstn = 1'b1;
    en   = 1'b1;
    hold(1'b0, 4);

    // Divide-by-6, then divide-by-10.
    run(3, 3, 24);
    run(5, 5, 6);

    // Signal lost: no rise for 300 cycles.
    hold(1'b0, 200);
    chk("pre_timeout", 32'(tmo), 0);
    hold(1'b0, 100);
    chk("timeout.flag",   32'(tmo), 1);
    chk("timeout.stable", 32'(stb), 0);
    chk("timeout.period", 32'(per), 10);
    chk("timeout.high",   32'(hi),  5);
    m_tmo = 1; m_stb = 0; m_armed = 0; m_mcnt = 0;

    // Recovery at divide-by-4.
    run(2, 2, 6);

    // Alternating 6/7 periods never reach a stable match.
    for (int k = 0; k < 4; k++) begin
      run(3, 3, 1);
      run(3, 4, 1);
    end

    // Random divisors and duty cycles.
    for (int s = 0; s < 8; s++) begin
      p = int'($urandom_range(20, 2));
      h = int'($urandom_range(p - 1, 1));
      n = int'($urandom_range(4, 1));
      run(h, p - h, n);
    end

    // Disable mid-period, re-enable with the same divisor: republish expected.
    run(3, 3, 4);
    hold(1'b1, 3);
    hold(1'b0, 2);
    en = 1'b0;
    model_disable();
    hold(1'b0, 3);
    chk("dis.stable",  32'(stb), 0);
    chk("dis.timeout", 32'(tmo), 0);
    chk("dis.tog",     32'(tog), m_tog);
    chk("dis.period",  32'(per), m_per);
    hold(1'b0, 47);
    en = 1'b1;
    hold(1'b0, 3);
    run(3, 3, 5);

    // Asynchronous reset in the middle of a high phase.
    hold(1'b1, 2);
    #3;
    rstn = 1'b0;
    #1;
    chk_all("async_rst", zero);
    q.delete();
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    hold(1'b0, 3);
    last_rise = cyc;
    run(3, 3, 5);
    hold(1'b0, 6);
    chk("final.tog",    32'(tog), 1);
    chk("final.period", 32'(per), 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
